// File: rtl/ram_pipelined_if.sv
`default_nettype none
// ============================================================================
// Module   : ram_pipelined_if
// Brief    : Request/response bundle for ram_pipelined (valid/ready request,
//            point-to-point read response).
// Revision : 1.0
// ============================================================================
interface ram_pipelined_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11
);
   logic                      chip_select;
   logic                      req_valid;
   logic                      req_ready;
   logic                      req_we;
   logic [ADDR_WIDTH-1:0]     req_addr;
   logic [DATA_WIDTH-1:0]     req_wdata;
   logic [DATA_WIDTH/8-1:0]   req_be;
   logic                      rsp_valid;
   logic [DATA_WIDTH-1:0]     rsp_data;
   logic                      rsp_err;

   modport master (
      output chip_select, req_valid, req_we, req_addr, req_wdata, req_be,
      input  req_ready, rsp_valid, rsp_data, rsp_err
   );

   modport slave (
      input  chip_select, req_valid, req_we, req_addr, req_wdata, req_be,
      output req_ready, rsp_valid, rsp_data, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : ram_pipelined
// Brief    : Single-port synchronous RAM, byte enables, READ_LATENCY-deep read
//            pipeline, self-clear after reset. Optional macro PARITY_EN adds
//            per-byte even parity with rsp_err reporting.
// Revision : 1.0
// ============================================================================
module ram_pipelined #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 11,
   parameter int READ_LATENCY = 1
) (
   input  logic           clock,
   input  logic           reset_n,
   ram_pipelined_if.slave bus
);
   localparam int                    c_bytes     = DATA_WIDTH / 8;
   localparam int                    c_depth     = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] c_last_addr = '1;

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   state_t                  r_state;
   logic                    r_ready;
   logic [ADDR_WIDTH-1:0]   r_clr_cnt;
   logic [DATA_WIDTH-1:0]   r_mem [c_depth];
   logic [READ_LATENCY-1:0] r_vld;
   logic [DATA_WIDTH-1:0]   r_dat [READ_LATENCY];

   logic                    w_accept;
   logic                    w_rd;
   logic                    w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_mem_addr;
   logic [DATA_WIDTH-1:0]   w_mem_wdata;
   logic [c_bytes-1:0]      w_mem_be;
   logic [DATA_WIDTH-1:0]   w_rd_word;

   assign w_accept  = bus.chip_select & bus.req_valid & r_ready;
   assign w_rd      = w_accept & ~bus.req_we;
   assign w_rd_word = r_mem[bus.req_addr];

   // The clear sequence owns the write port until every word is zeroed.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = bus.req_addr;
      w_mem_wdata = bus.req_wdata;
      w_mem_be    = bus.req_be;
      if (r_state == ST_CLEAR) begin
         w_mem_we    = 1'b1;
         w_mem_addr  = r_clr_cnt;
         w_mem_wdata = '0;
         w_mem_be    = '1;
      end else begin
         w_mem_we    = w_accept & bus.req_we;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= ST_CLEAR;
         r_ready   <= 1'b0;
         r_clr_cnt <= '0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + 1'b1;
               if (r_clr_cnt == c_last_addr) begin
                  r_state <= ST_READY;
                  r_ready <= 1'b1;
               end
            end
            ST_READY: r_ready <= 1'b1;
            default: begin
               r_state <= ST_CLEAR;
               r_ready <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         for (int i = 0; i < c_bytes; i++) begin
            if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_wdata[8*i +: 8];
         end
      end
   end

   // Each stage's data only moves with its valid, so the last stage holds
   // the previous read word while no response is presented.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_vld[0] <= 1'b0;
         r_dat[0] <= '0;
      end else begin
         r_vld[0] <= w_rd;
         if (w_rd) r_dat[0] <= w_rd_word;
      end
   end

   for (genvar g = 1; g < READ_LATENCY; g++) begin : g_stage
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_vld[g] <= 1'b0;
            r_dat[g] <= '0;
         end else begin
            r_vld[g] <= r_vld[g-1];
            if (r_vld[g-1]) r_dat[g] <= r_dat[g-1];
         end
      end
   end

   assign bus.req_ready = r_ready;
   assign bus.rsp_valid = r_vld[READ_LATENCY-1];
   assign bus.rsp_data  = r_dat[READ_LATENCY-1];

`ifdef PARITY_EN
   logic [c_bytes-1:0]      r_par [c_depth];
   logic [READ_LATENCY-1:0] r_err;
   logic [c_bytes-1:0]      w_par_wdata;
   logic [c_bytes-1:0]      w_par_rd;

   always_comb begin
      w_par_wdata = '0;
      w_par_rd    = '0;
      for (int i = 0; i < c_bytes; i++) begin
         w_par_wdata[i] = ^w_mem_wdata[8*i +: 8];
         w_par_rd[i]    = ^w_rd_word[8*i +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         for (int i = 0; i < c_bytes; i++) begin
            if (w_mem_be[i]) r_par[w_mem_addr][i] <= w_par_wdata[i];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_err[0] <= 1'b0;
      else if (w_rd) r_err[0] <= |(r_par[bus.req_addr] ^ w_par_rd);
   end

   for (genvar g = 1; g < READ_LATENCY; g++) begin : g_err_stage
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) r_err[g] <= 1'b0;
         else if (r_vld[g-1]) r_err[g] <= r_err[g-1];
      end
   end

   assign bus.rsp_err = r_err[READ_LATENCY-1] & r_vld[READ_LATENCY-1];
`else
   assign bus.rsp_err = 1'b0;
`endif
endmodule
`default_nettype wire

// File: tb/tb_ram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_pipelined
// Brief    : Scoreboard bench for ram_pipelined against a word-array model.
// Revision : 1.0
// ============================================================================
module tb_ram_pipelined;
   localparam int DW    = 32;
   localparam int AW    = 11;
   localparam int RL    = 3;
   localparam int DEPTH = 2 ** AW;

   typedef struct {
      logic [DW-1:0] data;
      logic          err;
      int            due;
   } exp_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b1;
   int   edge_cnt = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [DW-1:0] model [DEPTH];
   logic [DW-1:0] hold_exp = '0;
   exp_t          sb [$];

   ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   ram_pipelined #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .READ_LATENCY(RL)
   ) dut (
      .clock  (clock),
      .reset_n(reset_n),
      .bus    (bus)
   );

   always #5 clock = ~clock;
   always @(posedge clock) edge_cnt <= edge_cnt + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops an expectation whenever a response is presented.
   always @(negedge clock) begin
      if (reset_n) begin
         if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_rsp: rsp_valid=1 data=0x%0h at cycle %0d, required no response",
                        bus.rsp_data, edge_cnt);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("rsp_data", 64'(bus.rsp_data), 64'(e.data));
               check("rsp_err", 64'(bus.rsp_err), 64'(e.err));
               check("rsp_cycle", 64'(edge_cnt), 64'(e.due));
               hold_exp = e.data;
            end
         end else begin
            check("rsp_hold", 64'(bus.rsp_data), 64'(hold_exp));
            if (sb.size() > 0 && sb[0].due < edge_cnt) begin
               exp_t e;
               e = sb.pop_front();
               n_cmp++;
               n_bad++;
               $display("FAIL missing_rsp: no response at cycle %0d, required data 0x%0h", e.due, e.data);
            end
         end
      end
   end

   task automatic set_idle();
      bus.chip_select = 1'b0;
      bus.req_valid   = 1'b0;
      bus.req_we      = 1'b0;
      bus.req_addr    = '0;
      bus.req_wdata   = '0;
      bus.req_be      = '0;
   endtask

   task automatic drive_idle();
      @(posedge clock);
      #1;
      set_idle();
   endtask

   // One request cycle; the model follows the accept rule directly.
   task automatic issue(input logic cs, input logic vld, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] be, input logic perr);
      @(posedge clock);
      #1;
      bus.chip_select = cs;
      bus.req_valid   = vld;
      bus.req_we      = we;
      bus.req_addr    = a;
      bus.req_wdata   = d;
      bus.req_be      = be;
      if (cs && vld) begin
         if (we) begin
            for (int b = 0; b < 4; b++)
               if (be[b]) model[a][8*b +: 8] = d[8*b +: 8];
         end else begin
            sb.push_back('{data: model[a], err: perr, due: edge_cnt + RL});
         end
      end
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] be);
      issue(1'b1, 1'b1, 1'b1, a, d, be, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] a);
      issue(1'b1, 1'b1, 1'b0, a, '0, 4'h0, 1'b0);
   endtask

   task automatic apply_reset();
      int n;
      reset_n = 1'b0;
      #1;
      check("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("reset_req_ready", 64'(bus.req_ready), 64'd0);
      check("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
      check("reset_rsp_err", 64'(bus.rsp_err), 64'd0);
      sb.delete();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      hold_exp = '0;
      set_idle();
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      n = 0;
      while (n < DEPTH + 10) begin
         @(posedge clock);
         #1;
         n++;
         if (bus.req_ready) break;
      end
      check("clear_cycles", 64'(n), 64'(DEPTH));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      set_idle();
      #2;
      apply_reset();

      for (int i = 0; i < 4; i++) rd(AW'($urandom));
      drive_idle();

      wr(5, 32'hDEADBEEF, 4'hF);
      wr(5, 32'h000000AA, 4'h1);
      rd(5);
      drive_idle();

      wr(1, $urandom, 4'hF);
      wr(2, $urandom, 4'hF);
      wr(3, $urandom, 4'hF);
      rd(1);
      rd(2);
      rd(3);
      drive_idle();

      wr(7, 32'h12345678, 4'hF);
      rd(7);
      drive_idle();

      wr(5, 32'hFFFFFFFF, 4'h0);
      issue(1'b0, 1'b1, 1'b1, 5, 32'h11111111, 4'hF, 1'b0);
      issue(1'b0, 1'b1, 1'b0, 5, '0, 4'h0, 1'b0);
      rd(5);
      drive_idle();

      for (int i = 0; i < 400; i++) begin
         issue(($urandom % 8) != 0, ($urandom % 4) != 0, 1'($urandom),
               AW'($urandom % 16), $urandom, 4'($urandom), 1'b0);
      end
      drive_idle();

`ifdef PARITY_EN
      dut.r_par[9][0] = ~dut.r_par[9][0];
      issue(1'b1, 1'b1, 1'b0, 9, '0, 4'h0, 1'b1);
      rd(10);
      drive_idle();
`endif

      repeat (RL + 2) drive_idle();
      check("sb_drained", 64'(sb.size()), 64'd0);

      // Reset lands while one response is presented and two are in flight.
      wr(5, 32'hCAFEF00D, 4'hF);
      rd(1);
      rd(2);
      rd(3);
      @(posedge clock);
      #1;
      apply_reset();

      rd(5);
      rd(7);
      repeat (RL + 2) drive_idle();
      check("sb_drained_final", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
